// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between event, score and echo.
// Build option TX_CRLF_EN: terminate messages with CR LF instead of LF.

module uart_tx_sched #(
  parameter int ECHO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        echo_req,
  input  logic [7:0]  echo_byte,
  input  logic        score_req,
  input  logic [15:0] score,
  input  logic        event_req,
  input  logic [7:0]  event_char,
  input  logic        is_transmitting,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic [1:0]  cur_src,
  output logic        echo_drop,
  output logic        event_ovf
);

  localparam int PW = $clog2(ECHO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ECHO_DEPTH);
  localparam logic [7:0] SL = 8'(STARVE_LIMIT);

`ifdef TX_CRLF_EN
  localparam logic [2:0] SC_LEN = 3'd7;
  localparam logic [2:0] EV_LEN = 3'd4;
`else
  localparam logic [2:0] SC_LEN = 3'd6;
  localparam logic [2:0] EV_LEN = 3'd3;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t state;

  logic [7:0]    fifo [ECHO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          fifo_ne;
  logic          push;
  logic          pop;

  logic          score_pend;
  logic [15:0]   score_snap;
  logic          ev_pend;
  logic [7:0]    ev_char;
  logic [7:0]    starve_cnt;

  logic [7:0]    msg [8];
  logic [2:0]    idx;
  logic [2:0]    len;
  logic [2:0]    nxt_idx;

  logic          load;
  logic          starved;
  logic          win_ev;
  logic          win_sc;
  logic          win_echo;
  logic          any_req;
  logic [7:0]    nmsg [8];
  logic [2:0]    nlen;
  logic [1:0]    nsrc;

  assign busy = (state != IDLE);

  // Winner selection and the message image LOAD will capture.
  always_comb begin
    full     = (count == DEPTH_C);
    fifo_ne  = (count != '0);
    push     = echo_req && !full;
    load     = (state == LOAD);
    starved  = fifo_ne && (starve_cnt == SL);
    win_ev   = !starved && ev_pend;
    win_sc   = !starved && !ev_pend && score_pend;
    win_echo = starved || (!ev_pend && !score_pend && fifo_ne);
    pop      = load && win_echo;
    any_req  = ev_pend || score_pend || fifo_ne ||
               event_req || score_req || echo_req;
    nxt_idx  = idx + 3'd1;
    for (int i = 0; i < 8; i++) nmsg[i] = '0;
    nlen = '0;
    nsrc = '0;
    unique case (1'b1)
      win_ev: begin
        nmsg[0] = 8'h21;
        nmsg[1] = ev_char;
`ifdef TX_CRLF_EN
        nmsg[2] = 8'h0D;
        nmsg[3] = 8'h0A;
`else
        nmsg[2] = 8'h0A;
`endif
        nlen = EV_LEN;
        nsrc = 2'd1;
      end
      win_sc: begin
        nmsg[0] = 8'h53;
        nmsg[1] = 8'h30 + {4'h0, score_snap[15:12]};
        nmsg[2] = 8'h30 + {4'h0, score_snap[11:8]};
        nmsg[3] = 8'h30 + {4'h0, score_snap[7:4]};
        nmsg[4] = 8'h30 + {4'h0, score_snap[3:0]};
`ifdef TX_CRLF_EN
        nmsg[5] = 8'h0D;
        nmsg[6] = 8'h0A;
`else
        nmsg[5] = 8'h0A;
`endif
        nlen = SC_LEN;
        nsrc = 2'd2;
      end
      win_echo: begin
        nmsg[0] = fifo[rd_ptr];
        nlen    = 3'd1;
        nsrc    = 2'd3;
      end
      default: ;
    endcase
  end

  // Echo FIFO storage and pointers; count is sampled before the pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ECHO_DEPTH; i++) fifo[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= echo_byte;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Pending score/event requests; a new request beats a same-cycle consume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_pend <= 1'b0;
      score_snap <= '0;
      ev_pend    <= 1'b0;
      ev_char    <= '0;
      echo_drop  <= 1'b0;
      event_ovf  <= 1'b0;
    end else begin
      echo_drop <= echo_req && full;
      event_ovf <= event_req && ev_pend && !(load && win_ev);
      if (load && win_sc) score_pend <= 1'b0;
      if (score_req) begin
        score_pend <= 1'b1;
        score_snap <= score;
      end
      if (load && win_ev) ev_pend <= 1'b0;
      if (event_req) begin
        ev_pend <= 1'b1;
        ev_char <= event_char;
      end
    end
  end

  // Message sequencer with registered strobe, byte and source outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      for (int i = 0; i < 8; i++) msg[i] <= '0;
      idx        <= '0;
      len        <= '0;
      starve_cnt <= '0;
      transmit   <= 1'b0;
      tx_byte    <= '0;
      cur_src    <= '0;
    end else begin
      transmit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) state <= LOAD;
        end
        LOAD: begin
          if (win_ev || win_sc || win_echo) begin
            msg      <= nmsg;
            len      <= nlen;
            idx      <= '0;
            cur_src  <= nsrc;
            tx_byte  <= nmsg[0];
            transmit <= 1'b1;
            state    <= SEND;
            if (win_echo) starve_cnt <= '0;
            else if (fifo_ne && starve_cnt != 8'hFF)
              starve_cnt <= starve_cnt + 8'd1;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (is_transmitting) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!is_transmitting) begin
            if (nxt_idx < len) begin
              idx      <= nxt_idx;
              tx_byte  <= msg[nxt_idx];
              transmit <= 1'b1;
              state    <= SEND;
            end else begin
              cur_src <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Owns the UART transmit side: tx_byte/transmit into the uart instance, handshaking on is_transmitting.
- Shares that one transmitter between three requesters:
  - event banners (game start/over), from the control path;
  - BCD score reports;
  - a keystroke echo FIFO.
- Arbitration is non-preemptive and priority-based, with anti-starvation aging for echo.
- Sits beside control, between the game core and the uart instance.

Parameters:
- ECHO_DEPTH, 4: echo FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8: consecutive non-echo messages allowed while echo FIFO is non-empty (1..255).

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- echo_req, input, 1: pulse; push echo_byte into the echo FIFO.
- echo_byte, input, 8: byte to echo.
- score_req, input, 1: pulse; request a score report.
- score, input, 16: 4 BCD digits, [15:12] most significant.
- event_req, input, 1: pulse; request an event banner.
- event_char, input, 8: ASCII event code, e.g. "S" start, "O" over.
- is_transmitting, input, 1: uart busy flag.
- transmit, output, 1: one-cycle strobe to the uart.
- tx_byte, output, 8: byte presented with transmit; held stable until the next strobe.
- busy, output, 1: FSM not in IDLE.
- cur_src, output, 2: source of the message in flight: 0 none, 1 event, 2 score, 3 echo.
- echo_drop, output, 1: one-cycle pulse when an echo push is rejected.
- event_ovf, output, 1: one-cycle pulse when a pending event is overwritten.

Behaviour:
- Reset (async, any state, mid-message included):
  - FSM goes to IDLE; FIFO, pending flags and starve_cnt are cleared.
  - transmit=0, tx_byte=0, busy=0, cur_src=0, echo_drop=0, event_ovf=0.
- Echo FIFO:
  - Push on echo_req when count<ECHO_DEPTH; count is sampled before this cycle's pop.
  - A push when full is dropped and pulses echo_drop, even if a pop happens in the same cycle.
  - Pointers wrap modulo ECHO_DEPTH.
- Score pending:
  - score_req sets score_pend and latches score into score_snap.
  - A repeat request while pending overwrites score_snap (coalesce; no flag).
- Event pending:
  - event_req sets ev_pend and latches event_char.
  - If ev_pend is already set, the new char overwrites and event_ovf pulses.
- Requests arriving in the same cycle as a pending flag is consumed (LOAD) set it again; they are not lost.
- FSM states: IDLE -> LOAD -> SEND -> WAIT_HI -> WAIT_LO -> (SEND | IDLE).
  - IDLE: go to LOAD when any of ev_pend, score_pend or FIFO non-empty is set.
  - LOAD, winner selection:
    - If starve_cnt==STARVE_LIMIT and the FIFO is non-empty, echo wins.
    - Otherwise priority is event > score > echo.
  - LOAD copies the winner's data into a message buffer, clears its pending flag or pops the FIFO, sets byte index=0 and sets cur_src.
  - LOAD updates starve_cnt:
    - cleared when echo wins;
    - +1 (saturating) when event/score wins and the FIFO is non-empty;
    - unchanged otherwise.
  - SEND: drive tx_byte=buffer[index] and transmit=1 for exactly this one cycle.
  - WAIT_HI: wait until is_transmitting=1. There is no timeout.
  - WAIT_LO: wait until is_transmitting=0. Then index+1; return to SEND if bytes remain, else IDLE with cur_src=0.
- Message formats:
  - echo: 1 byte, the raw byte.
  - score: "S", then the 4 digits as 8'h30+digit (digits >9 are sent unconverted as 8'h3A..8'h3F), then the terminator.
  - event: "!", event_char, then the terminator.
- Latency: an idle scheduler with one request gives transmit 2 cycles after the request cycle (request cycle, then LOAD, then SEND).
- Back-to-back messages: earliest next LOAD is the cycle after WAIT_LO exits. The gap is 1 IDLE cycle.

Optional Feature:
- Macro: TX_CRLF_EN.
- Defined: terminator is 8'h0D, 8'h0A. Score message is 7 bytes, event 4.
- Undefined: terminator is 8'h0A only. Score message is 6 bytes, event 3.
- Echo is unaffected in both builds.

Test Plan:
- Score message (TX_CRLF_EN defined, bench uart model busy 10 cycles per byte): score_req with score=16'h0427 -> bytes 53,30,34,32,37,0D,0A.
  - transmit is exactly 1 cycle high per byte; first strobe 2 cycles after the request.
- Priority: echo_req("a"), score_req and event_req("O") in the same cycle -> event "!O" message, then score, then 61.
  - cur_src sequence 1, 2, 3.
- Echo overflow: 5 echo_req while busy sending a score message, ECHO_DEPTH=4 -> 5th push gives echo_drop=1 for one cycle.
  - The first 4 bytes are echoed in order afterwards.
- Starvation: FIFO holds 1 byte, score_req asserted continuously, STARVE_LIMIT=2 -> sequence score, score, echo, score.
- Overwrite/coalesce: two event_req ("S" then "O") while busy -> event_ovf pulses once; only "!O" is sent.
  - Two score_req during one score message -> exactly one further score message, carrying the latest value.
- Async reset in WAIT_HI of byte 3 -> outputs clear immediately; no further strobes; pending flags and FIFO are empty after release.
